// File: rtl/adder_pipe64_if.sv
`default_nettype none
// ============================================================================
// Module   : adder_pipe64_if
// Purpose  : Operand/result handshake bundle for the pipelined adder.
//            The issue side (master) drives operands and out_ready; the
//            adder (slave) drives in_ready and the registered result.
// Signals  : in_valid/in_ready    operand beat handshake
//            a, b, c_in, sub      operands and operation select
//            out_valid/out_ready  result beat handshake
//            sum, c_out,
//            overflow, zero       result and flags
// Revision : 1.0 - initial release
// ============================================================================
interface adder_pipe64_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, sum, c_out, overflow, zero
    );

    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, sum, c_out, overflow, zero
    );
endinterface
`default_nettype wire

// File: rtl/adder_pipe64.sv
`default_nettype none
// ============================================================================
// Module   : adder_pipe64
// Purpose  : Stallable pipelined add/subtract unit. One ripple slice of
//            WIDTH/SLICES bits per stage, carry registered between stages.
//            Unconsumed operand bits ride along (skew), finished sum slices
//            are carried forward (deskew) so the full result lines up in
//            the output register. Latency SLICES cycles, one beat/cycle.
// Ports    : clk  - system clock, rising edge
//            rst  - synchronous active-high reset
//            bus  - adder_pipe64_if.slave (operand and result handshakes)
// Revision : 1.0 - initial release
// ============================================================================
module adder_pipe64 #(
    parameter int WIDTH  = 64,
    parameter int SLICES = 4
) (
    input  wire logic       clk,
    input  wire logic       rst,
    adder_pipe64_if.slave   bus
);

    localparam int c_SLICE_W = WIDTH / SLICES;
    // Stage k (k = 0 .. SLICES-2) keeps WIDTH-(k+1)*S operand bits and
    // (k+1)*S finished sum bits; the per-stage fields are packed end to end.
    localparam int c_SKEW_TOT = (SLICES - 1) * WIDTH - c_SLICE_W * (SLICES - 1) * SLICES / 2;
    localparam int c_DONE_TOT = c_SLICE_W * (SLICES - 1) * SLICES / 2;
    localparam int c_LAST     = SLICES - 2;  // stage feeding the output register
    localparam int c_LAST_SKEW_OFF = c_LAST * WIDTH - c_SLICE_W * c_LAST * (c_LAST + 1) / 2;
    localparam int c_LAST_DONE_OFF = c_SLICE_W * c_LAST * (c_LAST + 1) / 2;

    if ((SLICES < 2) || ((WIDTH % SLICES) != 0)) begin : g_cfg_check
        $error("adder_pipe64: SLICES (%0d) must be >= 2 and divide WIDTH (%0d)", SLICES, WIDTH);
    end

    // Ripple chain of full-adder cells; returns {carry_out, sum}.
    function automatic logic [c_SLICE_W:0] f_ripple(
        input logic [c_SLICE_W-1:0] x,
        input logic [c_SLICE_W-1:0] y,
        input logic                 ci
    );
        logic [c_SLICE_W:0] r;
        logic               c;
        c = ci;
        r = '0;
        for (int i = 0; i < c_SLICE_W; i++) begin
            r[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        r[c_SLICE_W] = c;
        return r;
    endfunction

    // Single advance enable: the whole pipe moves or the whole pipe holds.
    logic w_adv;
    logic r_out_valid;
    assign w_adv        = !r_out_valid || bus.out_ready;
    assign bus.in_ready = w_adv;

    logic [c_SKEW_TOT-1:0] w_skew_a;
    logic [c_SKEW_TOT-1:0] w_skew_b;
    logic [c_DONE_TOT-1:0] w_done_q;
    logic [SLICES-2:0]     w_vld_q;
    logic [SLICES-2:0]     w_cy_q;

    for (genvar k = 0; k < SLICES - 1; k++) begin : g_stage
        localparam int c_IN_W     = WIDTH - k * c_SLICE_W;
        localparam int c_SKEW_W   = c_IN_W - c_SLICE_W;
        localparam int c_DONE_W   = (k + 1) * c_SLICE_W;
        localparam int c_SKEW_OFF = k * WIDTH - c_SLICE_W * k * (k + 1) / 2;
        localparam int c_DONE_OFF = c_SLICE_W * k * (k + 1) / 2;

        logic [c_IN_W-1:0]   w_a;
        logic [c_IN_W-1:0]   w_b_eff;
        logic                w_ci;
        logic                w_vld;
        logic [c_SLICE_W:0]  w_add;
        logic [c_DONE_W-1:0] w_done_nxt;

        logic                r_vld;
        logic                r_cy;
        logic [c_SKEW_W-1:0] r_a;
        logic [c_SKEW_W-1:0] r_b_eff;
        logic [c_DONE_W-1:0] r_done;

        if (k == 0) begin : g_head
            // Subtract is a + ~b + 1, so the inverted operand and forced
            // carry enter here and c_in is dropped.
            assign w_a        = bus.a;
            assign w_b_eff    = bus.sub ? ~bus.b : bus.b;
            assign w_ci       = bus.sub | bus.c_in;
            assign w_vld      = bus.in_valid && w_adv;
            assign w_done_nxt = w_add[c_SLICE_W-1:0];
        end else begin : g_body
            localparam int c_PREV_SKEW_OFF = (k - 1) * WIDTH - c_SLICE_W * (k - 1) * k / 2;
            localparam int c_PREV_DONE_OFF = c_SLICE_W * (k - 1) * k / 2;
            assign w_a        = w_skew_a[c_PREV_SKEW_OFF +: c_IN_W];
            assign w_b_eff    = w_skew_b[c_PREV_SKEW_OFF +: c_IN_W];
            assign w_ci       = w_cy_q[k-1];
            assign w_vld      = w_vld_q[k-1];
            assign w_done_nxt = {w_add[c_SLICE_W-1:0], w_done_q[c_PREV_DONE_OFF +: k * c_SLICE_W]};
        end

        assign w_add = f_ripple(w_a[c_SLICE_W-1:0], w_b_eff[c_SLICE_W-1:0], w_ci);

        always_ff @(posedge clk) begin
            if (rst) begin
                r_vld   <= 1'b0;
                r_cy    <= 1'b0;
                r_a     <= '0;
                r_b_eff <= '0;
                r_done  <= '0;
            end else if (w_adv) begin
                r_vld   <= w_vld;
                r_cy    <= w_add[c_SLICE_W];
                r_a     <= w_a[c_IN_W-1:c_SLICE_W];
                r_b_eff <= w_b_eff[c_IN_W-1:c_SLICE_W];
                r_done  <= w_done_nxt;
            end
        end

        assign w_skew_a[c_SKEW_OFF +: c_SKEW_W] = r_a;
        assign w_skew_b[c_SKEW_OFF +: c_SKEW_W] = r_b_eff;
        assign w_done_q[c_DONE_OFF +: c_DONE_W] = r_done;
        assign w_vld_q[k]                       = r_vld;
        assign w_cy_q[k]                        = r_cy;
    end

    // Final slice: its operand MSBs are the operand MSBs, so the signed
    // overflow rule is evaluated right here on the top slice.
    logic [c_SLICE_W-1:0] w_fa;
    logic [c_SLICE_W-1:0] w_fb;
    logic [c_SLICE_W:0]   w_fadd;
    logic [WIDTH-1:0]     w_fsum;

    assign w_fa   = w_skew_a[c_LAST_SKEW_OFF +: c_SLICE_W];
    assign w_fb   = w_skew_b[c_LAST_SKEW_OFF +: c_SLICE_W];
    assign w_fadd = f_ripple(w_fa, w_fb, w_cy_q[c_LAST]);
    assign w_fsum = {w_fadd[c_SLICE_W-1:0], w_done_q[c_LAST_DONE_OFF +: WIDTH - c_SLICE_W]};

    logic [WIDTH-1:0] r_sum;
    logic             r_c_out;
    logic             r_overflow;
    logic             r_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_c_out     <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= w_vld_q[c_LAST];
            r_sum       <= w_fsum;
            r_c_out     <= w_fadd[c_SLICE_W];
            r_overflow  <= (w_fa[c_SLICE_W-1] == w_fb[c_SLICE_W-1]) &&
                           (w_fadd[c_SLICE_W-1] != w_fa[c_SLICE_W-1]);
            r_zero      <= (w_fsum == '0);
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.sum       = r_sum;
    assign bus.c_out     = r_c_out;
    assign bus.overflow  = r_overflow;
    assign bus.zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_adder_pipe64.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_pipe64
// Purpose  : Self-checking bench for adder_pipe64. A queue of in-flight
//            beats, each with its age in cycles, predicts when results
//            appear and what they are (plain wide arithmetic).
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_pipe64;

    localparam int c_SLICES = 4;

    logic clk;
    logic rst;

    adder_pipe64_if #(.WIDTH(64)) bus ();

    adder_pipe64 #(.WIDTH(64), .SLICES(c_SLICES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [63:0] sum;
        logic        c_out;
        logic        ovf;
        logic        zero;
        int          age;
    } beat_t;

    beat_t mq[$];
    int    n_cmp     = 0;
    int    n_fail    = 0;
    int    n_acc     = 0;
    int    n_disc    = 0;
    int    n_dut_out = 0;
    bit    last_acc;
    bit    last_ov;

    function automatic beat_t model(input logic [63:0] a, input logic [63:0] b,
                                    input logic ci, input logic sb);
        beat_t       r;
        logic [63:0] be;
        logic        cin;
        logic [64:0] u;
        logic [65:0] s;
        be  = sb ? ~b : b;
        cin = sb ? 1'b1 : ci;
        u   = {1'b0, a} + {1'b0, be} + {64'd0, cin};
        s   = {{2{a[63]}}, a} + {{2{be[63]}}, be} + {65'd0, cin};
        r.sum   = u[63:0];
        r.c_out = u[64];
        r.ovf   = !((s[65] == s[63]) && (s[64] == s[63]));
        r.zero  = (u[63:0] == 64'd0);
        r.age   = 1;
        return r;
    endfunction

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 5))
            0:       return 64'hFFFF_FFFF_FFFF_FFFF;
            1:       return 64'h7FFF_FFFF_FFFF_FFFF;
            2:       return 64'h8000_0000_0000_0000;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [63:0] aa, input logic [63:0] bb,
                         input bit ci, input bit sb, input bit ordy);
        bus.in_valid  = v;
        bus.a         = aa;
        bus.b         = bb;
        bus.c_in      = ci;
        bus.sub       = sb;
        bus.out_ready = ordy;
    endtask

    // Check the cycle's outputs against the model, then advance one clock.
    task automatic tick();
        bit m_ov;
        bit m_adv;
        #1;
        last_acc = 1'b0;
        last_ov  = bus.out_valid;
        if (!rst) begin
            m_ov  = (mq.size() > 0) && (mq[0].age == c_SLICES);
            m_adv = !m_ov || bus.out_ready;
            chk("out_valid", bus.out_valid, 64'(m_ov));
            chk("in_ready", bus.in_ready, 64'(m_adv));
            if (m_ov) begin
                chk("sum", bus.sum, mq[0].sum);
                chk("c_out", bus.c_out, 64'(mq[0].c_out));
                chk("overflow", bus.overflow, 64'(mq[0].ovf));
                chk("zero", bus.zero, 64'(mq[0].zero));
            end
            if (bus.out_valid && bus.out_ready) n_dut_out++;
            if (m_adv) begin
                if (m_ov) void'(mq.pop_front());
                for (int i = 0; i < mq.size(); i++) mq[i].age = mq[i].age + 1;
                if (bus.in_valid) begin
                    mq.push_back(model(bus.a, bus.b, bus.c_in, bus.sub));
                    n_acc++;
                    last_acc = 1'b1;
                end
            end
        end
        @(posedge clk);
        if (rst) begin
            n_disc += mq.size();
            mq.delete();
        end
        @(negedge clk);
    endtask

    task automatic single(input string tag, input logic [63:0] aa, input logic [63:0] bb,
                          input bit ci, input bit sb, input logic [63:0] es,
                          input bit eco, input bit eov, input bit ez);
        int lat;
        drive(1'b1, aa, bb, ci, sb, 1'b1);
        tick();
        drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'd4);
        chk({tag, "_sum"}, bus.sum, es);
        chk({tag, "_c_out"}, 64'(bus.c_out), 64'(eco));
        chk({tag, "_overflow"}, 64'(bus.overflow), 64'(eov));
        chk({tag, "_zero"}, 64'(bus.zero), 64'(ez));
        tick();
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_sum"}, bus.sum, 64'd0);
        chk({tag, "_c_out"}, 64'(bus.c_out), 64'd0);
        chk({tag, "_overflow"}, 64'(bus.overflow), 64'd0);
        chk({tag, "_zero"}, 64'(bus.zero), 64'd0);
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        int          n0;
        int          k;
        int          c;
        int          first;
        int          cnt;
        int          pat[7];
        logic [63:0] ra;
        logic [63:0] rb;
        bit          rci;
        bit          rsb;

        pat = '{1, 0, 0, 1, 0, 1, 1};
        rst = 1'b1;
        drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        check_idle_outputs("reset");

        // Single beats with known answers.
        single("t1_add", 64'd5, 64'd3, 1'b0, 1'b0, 64'd8, 1'b0, 1'b0, 1'b0);
        single("t2_carry", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0,
               64'd0, 1'b1, 1'b0, 1'b1);
        single("t3_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
               64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
        single("t3_sub", 64'd3, 64'd5, 1'b1, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);

        // Eight back-to-back beats: results on eight consecutive cycles.
        first = -1;
        cnt   = 0;
        for (int t = 0; t < 16; t++) begin
            if (t < 8) drive(1'b1, 64'(t), 64'(t) * 64'h1_0001, 1'b0, 1'b0, 1'b1);
            else       drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
            tick();
            if (last_ov) begin
                if (first < 0) first = t;
                cnt++;
            end
        end
        chk("t4_first_out", 64'(first), 64'd4);
        chk("t4_count", 64'(cnt), 64'd8);

        // Six random beats against a toggling out_ready.
        n0  = n_dut_out;
        k   = 0;
        c   = 0;
        ra  = rnd64();
        rb  = rnd64();
        rci = 1'($urandom);
        rsb = 1'($urandom);
        while (c < 100 && (k < 6 || (n_dut_out - n0) < 6)) begin
            drive(k < 6, ra, rb, rci, rsb, pat[c % 7] != 0);
            tick();
            if (last_acc) begin
                k++;
                ra  = rnd64();
                rb  = rnd64();
                rci = 1'($urandom);
                rsb = 1'($urandom);
            end
            c++;
        end
        chk("t5_delivered", 64'(n_dut_out - n0), 64'd6);

        // Reset with three beats in flight: nothing may emerge.
        for (int j = 0; j < 3; j++) begin
            drive(1'b1, rnd64(), rnd64(), 1'($urandom), 1'($urandom), 1'b1);
            tick();
        end
        drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_outputs("t6_after_rst");
        n0 = n_dut_out;
        for (int j = 0; j < 10; j++) tick();
        chk("t6_no_output", 64'(n_dut_out - n0), 64'd0);
        single("t6_fresh", 64'h0000_0001_0000_FFFF, 64'h0000_0000_0000_0001, 1'b0, 1'b0,
               64'h0000_0001_0001_0000, 1'b0, 1'b0, 1'b0);

        // Random traffic with random stalls.
        for (int j = 0; j < 120; j++) begin
            drive(1'($urandom), rnd64(), rnd64(), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 3) != 0);
            tick();
        end
        c = 0;
        drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
        while (mq.size() > 0 && c < 50) begin
            tick();
            c++;
        end
        chk("total_delivered", 64'(n_dut_out), 64'(n_acc - n_disc));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
